pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC and pipeline-control sequencer for the 5-stage pipelined CPU. Each cycle it chooses the next fetch address from sequential, jump and branch sources and drives the PC register's `pc_i`/`stall_i`. It generates the stall, flush, bubble and freeze controls for load-use hazards and data-memory stalls. It also defers any redirect that collides with a memory stall, and keeps cycle, stall and flush performance counters.

## Interface
Parameters: none (fixed 32-bit datapath, 4-byte instructions).

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  run enable; 0 forces IDLE
- pc_i  in  32  current PC (PC register output)
- jump_i  in  1  jump resolved in ID
- jump_target_i  in  32  jump destination
- branch_i  in  1  branch taken, resolved in ID
- branch_target_i  in  32  branch destination
- hazard_i  in  1  load-use hazard from the hazard-detection unit
- mem_stall_i  in  1  data memory busy; the whole pipeline must hold
- pc_next_o  out  32  next PC, drives PC `pc_i`
- pc_stall_o  out  1  drives PC `stall_i`
- ifid_stall_o  out  1  hold the IF/ID register
- ifid_flush_o  out  1  clear the IF/ID register to a NOP
- idex_bubble_o  out  1  insert a NOP into ID/EX
- pipe_freeze_o  out  1  hold all pipeline registers
- state_o  out  2  IDLE=00, RUN=01, FREEZE=10
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  32 each  performance counters

## Operation
- **State machine.** State is registered. Outputs are combinational from state and inputs (Mealy).
- **Defaults.** Every output is 0 unless listed below. The default `pc_next_o` is `pc_i`.
- **IDLE.**
  - Outputs: `pc_next_o`=0, `pc_stall_o`=1.
  - Transition: start_i=1 → RUN.
- **RUN with mem_stall_i=1.**
  - Outputs: `pc_stall_o`=1, `pipe_freeze_o`=1.
  - If jump_i or branch_i is also 1, latch a pending redirect. The target is jump_target_i if jump_i=1, otherwise branch_target_i.
  - Transition: → FREEZE.
- **RUN with mem_stall_i=0.** Priority is hazard > jump > branch > sequential.
  - hazard_i: `pc_stall_o`=1, `ifid_stall_o`=1, `idex_bubble_o`=1. jump_i and branch_i are ignored this cycle; ID re-evaluates them next cycle.
  - jump_i: `pc_next_o`=jump_target_i, `ifid_flush_o`=1.
  - branch_i: `pc_next_o`=branch_target_i, `ifid_flush_o`=1.
  - Otherwise: `pc_next_o`=pc_i+4, with modulo-2^32 wrap.
- **FREEZE.**
  - While mem_stall_i=1: `pc_stall_o`=1, `pipe_freeze_o`=1. jump_i, branch_i and hazard_i are ignored.
  - Exit cycle (mem_stall_i=0), pending redirect set: `pc_next_o`=pending target, `ifid_flush_o`=1. The pending redirect is cleared at the edge and the state goes to RUN.
  - Exit cycle, no pending redirect: behave exactly as RUN with mem_stall_i=0 (same priority rules), then go to RUN.
- **start_i=0 in any state.** Outputs as in IDLE that cycle. Next state is IDLE, the pending redirect is cleared, counters hold.
- **Counters** (32-bit, wrap 2^32-1 → 0):
  - cycle_cnt: +1 every cycle the state is not IDLE and start_i=1.
  - stall_cnt: +1 every cycle `pc_stall_o`=1 outside IDLE.
  - flush_cnt: +1 every cycle `ifid_flush_o`=1.
- **Reset.** rst_i=0 forces, asynchronously and at any time (including mid-FREEZE): state IDLE, pending redirect and target cleared, all counters 0. Outputs then take their IDLE values.

## Timing
- `pc_next_o` and all controls are valid in the same cycle as their inputs (zero-latency combinational). The PC and pipeline registers act on the next rising edge.
- Redirect: the target appears at the PC one edge after jump_i/branch_i is seen. Exactly one `ifid_flush_o` cycle is generated per redirect.
- Load-use hazard: exactly one stall cycle per cycle hazard_i is high.
- Memory stall of N cycles in RUN: N cycles of freeze (the RUN cycle plus N-1 FREEZE cycles), then the exit cycle.
- A deferred redirect is applied on the exit cycle. Its target is in the PC one edge later.
- The start_i edge IDLE→RUN takes effect on the next edge. The first RUN cycle fetches from pc_i=0.
- Counter outputs reflect updates from the previous edge (registered).

## Test plan
- Reset then start_i=1 with no events: pc_next_o steps 0, 4, 8, 12. cycle_cnt=4 after 4 RUN cycles. stall_cnt=0.
- pc_i=0x20, branch_i=1, branch_target_i=0x100: pc_next_o=0x100 and ifid_flush_o=1 for one cycle. flush_cnt=1.
- hazard_i=1 together with branch_i=1 for one cycle: pc_stall_o=ifid_stall_o=idex_bubble_o=1, no flush. Next cycle with branch_i=1 only: redirect taken.
- mem_stall_i=1 for 3 cycles with jump_i=1 (target 0x40) on the first cycle:
  - pipe_freeze_o=1 for 3 cycles, state_o=10 on cycles 2-3.
  - Exit cycle: pc_next_o=0x40, ifid_flush_o=1.
  - stall_cnt=3.
- rst_i pulsed low mid-FREEZE with a pending redirect: immediate state_o=00, counters 0. After restart, no flush occurs and the PC starts at 0.
- Preload the counters near wrap (run 2^32-2 cycles, or force): cycle_cnt goes 0xFFFFFFFF → 0. Also, start_i=0 during RUN → IDLE with counters frozen.

Source files
------------

// File: rtl/pc_sequencer.sv
// Next-PC selection and pipeline control sequencer.
// Handles load-use stalls, memory freezes with deferred redirects, and perf counters.
module pc_sequencer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        hazard_i,
  input  logic        mem_stall_i,
  output logic [31:0] pc_next_o,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        pipe_freeze_o,
  output logic [1:0]  state_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    FREEZE = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        pend_q;
  logic [31:0] ptgt_q;
  logic [31:0] cycle_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic        normal;
  logic        active;
  logic        capture;
  logic        release_pend;

  assign active       = start_i && (state_q != IDLE);
  assign capture      = active && (state_q == RUN)
                        && mem_stall_i && (jump_i || branch_i);
  assign release_pend = active && (state_q == FREEZE) && !mem_stall_i;

  always_comb begin
    pc_next_o     = pc_i;
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    pipe_freeze_o = 1'b0;
    normal        = 1'b0;
    state_d       = state_q;
    if (!start_i || state_q == IDLE) begin
      pc_next_o  = 32'd0;
      pc_stall_o = 1'b1;
      state_d    = start_i ? RUN : IDLE;
    end else if (mem_stall_i) begin
      pc_stall_o    = 1'b1;
      pipe_freeze_o = 1'b1;
      state_d       = FREEZE;
    end else begin
      state_d = RUN;
      if (state_q == FREEZE && pend_q) begin
        pc_next_o    = ptgt_q;
        ifid_flush_o = 1'b1;
      end else begin
        normal = 1'b1;
      end
    end
    // Hazard outranks redirects; ID re-presents the redirect next cycle.
    if (normal) begin
      if (hazard_i) begin
        pc_stall_o    = 1'b1;
        ifid_stall_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if (jump_i) begin
        pc_next_o    = jump_target_i;
        ifid_flush_o = 1'b1;
      end else if (branch_i) begin
        pc_next_o    = branch_target_i;
        ifid_flush_o = 1'b1;
      end else begin
        pc_next_o = pc_i + 32'd4;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      ptgt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (!start_i || release_pend) begin
        pend_q <= 1'b0;
      end else if (capture) begin
        pend_q <= 1'b1;
        ptgt_q <= jump_i ? jump_target_i : branch_target_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (active)
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (active && pc_stall_o)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush_o)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign state_o     = state_q;
  assign cycle_cnt_o = cycle_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model expectations,
// a negedge monitor pops and compares.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        hazard_i;
  logic        mem_stall_i;
  logic [31:0] pc_next_o;
  logic        pc_stall_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        pipe_freeze_o;
  logic [1:0]  state_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;

  pc_sequencer dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .pc_i            (pc_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .hazard_i        (hazard_i),
    .mem_stall_i     (mem_stall_i),
    .pc_next_o       (pc_next_o),
    .pc_stall_o      (pc_stall_o),
    .ifid_stall_o    (ifid_stall_o),
    .ifid_flush_o    (ifid_flush_o),
    .idex_bubble_o   (idex_bubble_o),
    .pipe_freeze_o   (pipe_freeze_o),
    .state_o         (state_o),
    .cycle_cnt_o     (cycle_cnt_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc_next;
    logic [4:0]  ctl;
    logic [1:0]  st;
    logic [31:0] cyc;
    logic [31:0] stl;
    logic [31:0] fl;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: mode 0 idle, 1 run, 2 frozen.
  int          m_mode;
  bit          m_pend;
  logic [31:0] m_ptgt;
  logic [31:0] m_cyc;
  logic [31:0] m_stl;
  logic [31:0] m_fl;
  logic [31:0] m_pc;

  task automatic model_reset();
    m_mode = 0;
    m_pend = 0;
    m_ptgt = 32'd0;
    m_cyc  = 32'd0;
    m_stl  = 32'd0;
    m_fl   = 32'd0;
    m_pc   = 32'd0;
  endtask

  task automatic step(input bit r, input bit s, input bit j,
                      input bit b, input bit h, input bit ms,
                      input logic [31:0] jt, input logic [31:0] bt);
    exp_t e;
    bit   stall, fstall, flush, bub, frz, busy;
    @(posedge clk);
    #1;
    rst_i           = r;
    start_i         = s;
    jump_i          = j;
    branch_i        = b;
    hazard_i        = h;
    mem_stall_i     = ms;
    jump_target_i   = jt;
    branch_target_i = bt;
    if (!r) model_reset();
    pc_i = m_pc;
    stall = 0; fstall = 0; flush = 0; bub = 0; frz = 0;
    e.pc_next = m_pc;
    busy = s && (m_mode != 0);
    if (!busy) begin
      e.pc_next = 32'd0;
      stall = 1;
    end else if (ms) begin
      stall = 1;
      frz = 1;
    end else if (m_mode == 2 && m_pend) begin
      e.pc_next = m_ptgt;
      flush = 1;
    end else if (h) begin
      stall = 1; fstall = 1; bub = 1;
    end else if (j) begin
      e.pc_next = jt;
      flush = 1;
    end else if (b) begin
      e.pc_next = bt;
      flush = 1;
    end else begin
      e.pc_next = m_pc + 32'd4;
    end
    e.ctl = {stall, fstall, flush, bub, frz};
    e.st  = 2'(m_mode);
    e.cyc = m_cyc;
    e.stl = m_stl;
    e.fl  = m_fl;
    q.push_back(e);
    if (r) begin
      if (busy) m_cyc = m_cyc + 1;
      if (busy && stall) m_stl = m_stl + 1;
      if (flush) m_fl = m_fl + 1;
      if (!stall) m_pc = e.pc_next;
      if (!s) begin
        m_mode = 0;
        m_pend = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else begin
        if (m_mode == 1 && ms && (j || b)) begin
          m_pend = 1;
          m_ptgt = j ? jt : bt;
        end
        if (m_mode == 2 && !ms) m_pend = 0;
        m_mode = ms ? 2 : 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_next", pc_next_o, e.pc_next);
      chk("ctl{stall,ifid_stall,flush,bubble,freeze}",
          {27'd0, pc_stall_o, ifid_stall_o, ifid_flush_o,
           idex_bubble_o, pipe_freeze_o}, {27'd0, e.ctl});
      chk("state", {30'd0, state_o}, {30'd0, e.st});
      chk("cycle_cnt", cycle_cnt_o, e.cyc);
      chk("stall_cnt", stall_cnt_o, e.stl);
      chk("flush_cnt", flush_cnt_o, e.fl);
    end
  end

  initial begin
    rst_i = 0; start_i = 0; pc_i = 0; jump_i = 0; branch_i = 0;
    hazard_i = 0; mem_stall_i = 0; jump_target_i = 0; branch_target_i = 0;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    // Start and run sequentially
    step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 32'h100);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    // Hazard with branch, then branch alone
    step(1, 1, 0, 1, 1, 0, 0, 32'h200);
    step(1, 1, 0, 1, 0, 0, 0, 32'h200);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    // Three-cycle memory stall with a colliding jump
    step(1, 1, 1, 0, 0, 1, 32'h40, 0);
    step(1, 1, 1, 1, 1, 1, 32'h80, 32'h90);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    // Reset mid-freeze with a pending branch
    step(1, 1, 0, 1, 0, 1, 0, 32'h300);
    step(1, 1, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
    // Cycle counter wrap
    step(1, 1, 0, 0, 0, 0, 0, 0);
    #5;
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_q;
    m_cyc = 32'hFFFF_FFFF;
    repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
    // Drop start during run, counters must hold
    step(1, 0, 1, 0, 0, 0, 32'h44, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, s;
      r = ($urandom_range(0, 199) != 0);
      s = ($urandom_range(0, 39) != 0);
      step(r, s,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) == 0,
           $urandom() & 32'hFFFF_FFFC,
           $urandom() & 32'hFFFF_FFFC);
    end
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
